// File: rtl/enc_gray_codec_pipe.sv
// rtl/enc_gray_codec_pipe.sv - pipelined binary<->Gray converter with valid/ready handshake.
// Define ENC_GRAY_ROUNDTRIP_CHECK_EN to enable the output round-trip checker that drives out_err.
module enc_gray_codec_pipe #(
  parameter int WIDTH  = 10,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;

  typedef logic [WIDTH-1:0] word_t;

  function automatic word_t b2g(input word_t b);
    return b ^ (b >> 1);
  endfunction

  // Resolve Gray bits [hi-1:lo] to binary; bits above hi-1 must already be binary.
  function automatic word_t g2b_part(input word_t w, input int lo, input int hi);
    word_t r;
    r = w;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      if (i >= lo && i < hi) r[i] = r[i+1] ^ r[i];
    end
    return r;
  endfunction

  function automatic word_t g2b_stage(input word_t w, input int s);
    return g2b_part(w, WIDTH - (s + 1) * CHUNK, WIDTH - s * CHUNK);
  endfunction

  logic                          advance;
  logic [STAGES-1:0]             vld_q, vld_d;
  logic [STAGES-1:0]             mode_q, mode_d;
  logic [STAGES-1:0][WIDTH-1:0]  dat_q, dat_d;

`ifdef ENC_GRAY_ROUNDTRIP_CHECK_EN
  function automatic word_t g2b_full(input word_t w);
    return g2b_part(w, 0, WIDTH);
  endfunction

  logic [STAGES-1:0][WIDTH-1:0]  orig_q, orig_d;
  logic                          err_q, err_d;
`endif

  always_comb begin
    advance = ~vld_q[STAGES-1] | out_ready;
    vld_d   = vld_q;
    mode_d  = mode_q;
    dat_d   = dat_q;
`ifdef ENC_GRAY_ROUNDTRIP_CHECK_EN
    orig_d  = orig_q;
    err_d   = err_q;
`endif
    if (advance) begin
      vld_d[0]  = in_valid;
      mode_d[0] = in_mode;
      dat_d[0]  = in_mode ? g2b_stage(in_data, 0) : b2g(in_data);
`ifdef ENC_GRAY_ROUNDTRIP_CHECK_EN
      orig_d[0] = in_data;
`endif
      // Mode 0 words are finished at stage 0 and simply ride along for equal latency.
      for (int s = 1; s < STAGES; s++) begin
        vld_d[s]  = vld_q[s-1];
        mode_d[s] = mode_q[s-1];
        dat_d[s]  = mode_q[s-1] ? g2b_stage(dat_q[s-1], s) : dat_q[s-1];
`ifdef ENC_GRAY_ROUNDTRIP_CHECK_EN
        orig_d[s] = orig_q[s-1];
`endif
      end
`ifdef ENC_GRAY_ROUNDTRIP_CHECK_EN
      err_d = vld_d[STAGES-1] &
              (mode_d[STAGES-1] ? (b2g(dat_d[STAGES-1]) != orig_d[STAGES-1])
                                : (g2b_full(dat_d[STAGES-1]) != orig_d[STAGES-1]));
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      mode_q <= '0;
      dat_q  <= '0;
`ifdef ENC_GRAY_ROUNDTRIP_CHECK_EN
      orig_q <= '0;
      err_q  <= 1'b0;
`endif
    end else begin
      vld_q  <= vld_d;
      mode_q <= mode_d;
      dat_q  <= dat_d;
`ifdef ENC_GRAY_ROUNDTRIP_CHECK_EN
      orig_q <= orig_d;
      err_q  <= err_d;
`endif
    end
  end

  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES-1];
  assign out_mode  = mode_q[STAGES-1];
  assign out_data  = dat_q[STAGES-1];
`ifdef ENC_GRAY_ROUNDTRIP_CHECK_EN
  assign out_err   = err_q;
`else
  assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_enc_gray_codec_pipe.sv
// tb/tb_enc_gray_codec_pipe.sv - scoreboard bench for enc_gray_codec_pipe (WIDTH=10, STAGES=2).
module tb_enc_gray_codec_pipe;
  localparam int W = 10;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, in_mode, out_valid, out_ready, out_mode, out_err;
  logic [W-1:0] in_data, out_data;

  enc_gray_codec_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
    .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         mode;
    logic [W-1:0] data;
    logic         err;
    logic         skip;
    int           acc;
  } exp_t;

  exp_t         sbq[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  bit           lat_chk = 0;
  bit           onebit_chk = 0;
  bit           rand_rdy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] m_b2g(input logic [W-1:0] x);
    return x ^ (x >> 1);
  endfunction

  function automatic logic [W-1:0] m_g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int k = 1; k < W; k++) b = b ^ (g >> k);
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake, checks hold-stability under stall.
  initial begin
    exp_t         e;
    bit           hold_prev;
    bit           have_prev;
    logic [W-1:0] hold_data, prev_g;
    logic         hold_mode, hold_err;
    hold_prev = 0;
    have_prev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 0;
        have_prev = 0;
        continue;
      end
      if (out_valid) begin
        if (hold_prev) begin
          check("stall_data", out_data, hold_data);
          check("stall_mode", out_mode, hold_mode);
          check("stall_err", out_err, hold_err);
        end
        if (out_ready) begin
          hold_prev = 0;
          if (sbq.size() == 0) begin
            check("unexpected_out", 1, 0);
          end else begin
            e = sbq.pop_front();
            if (!e.skip) check("out_data", out_data, e.data);
            check("out_mode", out_mode, e.mode);
            check("out_err", out_err, e.err);
            if (lat_chk) check("latency", cyc - e.acc, S);
            if (onebit_chk && out_mode == 1'b0) begin
              if (have_prev) check("gray_onebit", $countones(prev_g ^ out_data), 1);
              prev_g    = out_data;
              have_prev = 1;
            end
          end
        end else begin
          hold_prev = 1;
          hold_data = out_data;
          hold_mode = out_mode;
          hold_err  = out_err;
        end
      end else begin
        hold_prev = 0;
      end
    end
  end

  task automatic send(input logic m, input logic [W-1:0] d, input logic [W-1:0] ex,
                      input logic er, input logic sk);
    int tries;
    bit done;
    tries    = 0;
    done     = 0;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    while (!done) begin
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back('{mode: m, data: ex, err: er, skip: sk, acc: cyc});
        done = 1;
      end
      @(posedge clk);
      #1;
      tries++;
      if (!done && tries > 200) begin
        check("send_timeout", 0, 1);
        done = 1;
      end
    end
  endtask

  task automatic send_m(input logic m, input logic [W-1:0] d);
    send(m, d, m ? m_g2b(d) : m_b2g(d), 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      in_data = W'($urandom);
      in_mode = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int t;
    t         = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sbq.size() > 0 && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_empty", sbq.size(), 0);
  endtask

  initial begin
    #3000000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [W-1:0]             bp[4];
    logic [S-1:0][W-1:0]      tmp;
    logic [W-1:0]             d;
    logic                     m;
    int                       k;

    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_mode", out_mode, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    lat_chk = 1;
    send(0, 10'h005, 10'h007, 0, 0); idle(3);
    send(0, 10'h3FF, 10'h200, 0, 0); idle(3);
    send(0, 10'h000, 10'h000, 0, 0); idle(3);
    send(1, 10'h007, 10'h005, 0, 0); idle(3);
    send(1, 10'h200, 10'h3FF, 0, 0); idle(3);
    send(1, 10'h155, 10'h199, 0, 0);
    drain();

    onebit_chk = 1;
    for (int i = 0; i < 1024; i++) send_m(0, W'(i));
    for (int i = 0; i < 1024; i++) send(1, m_b2g(W'(i)), W'(i), 0, 0);
    drain();
    onebit_chk = 0;
    lat_chk    = 0;

    idle(2);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) bp[i] = W'($urandom);
    k = 0;
    for (int c = 0; c < 5; c++) begin
      in_data = bp[k];
      in_mode = k[0];
      @(negedge clk);
      check("bp_in_ready", in_ready, (c < 2) ? 1 : 0);
      if (in_ready) begin
        sbq.push_back('{mode: k[0], data: k[0] ? m_g2b(bp[k]) : m_b2g(bp[k]),
                        err: 0, skip: 0, acc: cyc});
        k++;
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    while (k < 4) begin
      send_m(k[0], bp[k]);
      k++;
    end
    drain();

    idle(2);
    out_ready = 1'b0;
    send_m(0, W'($urandom));
    send_m(1, W'($urandom));
    in_valid = 1'b0;
    rst      = 1'b1;
    sbq.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("no_stale_word", out_valid, 0);
    end
    @(posedge clk);
    #1;

    rand_rdy = 1;
    for (int i = 0; i < 1000; i++) begin
      send_m(1'($urandom), W'($urandom));
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    rand_rdy = 0;
    drain();

`ifdef ENC_GRAY_ROUNDTRIP_CHECK_EN
    idle(3);
    d = W'($urandom);
    m = 1'($urandom);
    send(m, d, m ? m_g2b(d) : m_b2g(d), 1'b1, 1'b1);
    in_valid = 1'b0;
    tmp = dut.dat_q;
    tmp[0][0] = ~tmp[0][0];
    force dut.dat_q = tmp;
    @(posedge clk);
    #1;
    release dut.dat_q;
    idle(3);
    for (int i = 0; i < 8; i++) send_m(1'($urandom), W'($urandom));
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
